// File: rtl/traffic_monitor.sv
// traffic_monitor: safety monitor on the traffic controller's light interface.
// Forwards the observed lights while healthy. Checks run every cycle:
// light encodings, signal conflicts, phase order and phase lengths.
// On the first violation the monitor latches a fault code and drives
// flashing red, with the walk lamp off, until faultClr.
// One clock tick corresponds to one controller second.
module traffic_monitor #(
    parameter int YELLOW_T  = 2,
    parameter int WALK_T    = 3,
    parameter int MIN_GREEN = 6,
    parameter int MAX_GREEN = 12,
    parameter int CNT_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mainLights,
    input  logic [2:0] sideLights,
    input  logic       walkLamp,
    input  logic       faultClr,
    output logic       fault,
    output logic [2:0] faultCode,
    output logic [2:0] mainOut,
    output logic [2:0] sideOut,
    output logic       walkOut
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic is_legal(input logic [2:0] l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

    // Forbidden transitions: green->red, yellow->green, red->yellow.
    function automatic logic bad_step(input logic [2:0] p, input logic [2:0] c);
        return ((p == GRN) && (c == RED)) || ((p == YEL) && (c == GRN)) ||
               ((p == RED) && (c == YEL));
    endfunction

    function automatic logic [CNT_W-1:0] cnt_next(input logic chg, input logic [CNT_W-1:0] c);
        if (chg) return CNT_ONE;
        if (c == CNT_MAX) return c;
        return c + CNT_ONE;
    endfunction

    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;
    logic             flash_q, flash_d;
    logic [2:0]       prev_main_q, prev_main_d, prev_side_q, prev_side_d;
    logic             prev_walk_q, prev_walk_d;
    logic [CNT_W-1:0] cnt_main_q, cnt_main_d, cnt_side_q, cnt_side_d, cnt_walk_q, cnt_walk_d;
    logic             armed_main_q, armed_main_d, armed_side_q, armed_side_d;
    logic             armed_walk_q, armed_walk_d;
    logic             seq_valid_q, seq_valid_d;

    logic             main_chg, side_chg, walk_chg;
    logic             f_enc, f_conf, f_walk, f_seq, f_yel, f_grn, f_wlk;
    logic [2:0]       new_code;

    // Fault detection on the current sample against the tracked phase history.
    always_comb begin
        main_chg = mainLights != prev_main_q;
        side_chg = sideLights != prev_side_q;
        walk_chg = walkLamp != prev_walk_q;

        f_enc  = !is_legal(mainLights) || !is_legal(sideLights);
        f_conf = (mainLights != RED) && (sideLights != RED);
        f_walk = walkLamp && ((mainLights != RED) || (sideLights != RED));
        f_seq  = seq_valid_q && (bad_step(prev_main_q, mainLights) ||
                                 bad_step(prev_side_q, sideLights));
        f_yel  = (main_chg && (prev_main_q == YEL) && armed_main_q &&
                  (cnt_main_q != CNT_W'(YELLOW_T))) ||
                 (side_chg && (prev_side_q == YEL) && armed_side_q &&
                  (cnt_side_q != CNT_W'(YELLOW_T)));
        // The max-green check does not depend on the armed flags, so a green that
        // was already running at reset or clear is still bounded.
        f_grn  = (main_chg && (prev_main_q == GRN) && armed_main_q &&
                  (cnt_main_q < CNT_W'(MIN_GREEN))) ||
                 (side_chg && (prev_side_q == GRN) && armed_side_q &&
                  (cnt_side_q < CNT_W'(MIN_GREEN))) ||
                 (!main_chg && (mainLights == GRN) && (cnt_main_q >= CNT_W'(MAX_GREEN))) ||
                 (!side_chg && (sideLights == GRN) && (cnt_side_q >= CNT_W'(MAX_GREEN)));
        f_wlk  = walk_chg && prev_walk_q && armed_walk_q && (cnt_walk_q != CNT_W'(WALK_T));

        new_code = 3'd0;
        if (f_enc)       new_code = 3'd1;
        else if (f_conf) new_code = 3'd2;
        else if (f_walk) new_code = 3'd3;
        else if (f_seq)  new_code = 3'd4;
        else if (f_yel)  new_code = 3'd5;
        else if (f_grn)  new_code = 3'd6;
        else if (f_wlk)  new_code = 3'd7;
    end

    // Next-state: phase tracking, fault latching and clear handling.
    always_comb begin
        prev_main_d  = mainLights;
        prev_side_d  = sideLights;
        prev_walk_d  = walkLamp;
        cnt_main_d   = cnt_next(main_chg, cnt_main_q);
        cnt_side_d   = cnt_next(side_chg, cnt_side_q);
        cnt_walk_d   = cnt_next(walk_chg, cnt_walk_q);
        // A change seen on the first cycle after reset or clear compares the
        // sample against the reset value of the previous-sample register, so it
        // does not arm duration checks.
        armed_main_d = armed_main_q | (main_chg & seq_valid_q);
        armed_side_d = armed_side_q | (side_chg & seq_valid_q);
        armed_walk_d = armed_walk_q | (walk_chg & seq_valid_q);
        seq_valid_d  = 1'b1;
        fault_d      = fault_q;
        code_d       = code_q;
        flash_d      = ~flash_q;

        if ((new_code != 3'd0) && (!fault_q || faultClr)) begin
            fault_d = 1'b1;
            code_d  = new_code;
            flash_d = 1'b1;
        end else if (faultClr) begin
            fault_d      = 1'b0;
            code_d       = 3'd0;
            flash_d      = 1'b1;
            cnt_main_d   = CNT_ONE;
            cnt_side_d   = CNT_ONE;
            cnt_walk_d   = CNT_ONE;
            armed_main_d = 1'b0;
            armed_side_d = 1'b0;
            armed_walk_d = 1'b0;
            seq_valid_d  = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q      <= 1'b0;
            code_q       <= 3'd0;
            flash_q      <= 1'b1;
            prev_main_q  <= RED;
            prev_side_q  <= RED;
            prev_walk_q  <= 1'b0;
            cnt_main_q   <= CNT_ONE;
            cnt_side_q   <= CNT_ONE;
            cnt_walk_q   <= CNT_ONE;
            armed_main_q <= 1'b0;
            armed_side_q <= 1'b0;
            armed_walk_q <= 1'b0;
            seq_valid_q  <= 1'b0;
        end else begin
            fault_q      <= fault_d;
            code_q       <= code_d;
            flash_q      <= flash_d;
            prev_main_q  <= prev_main_d;
            prev_side_q  <= prev_side_d;
            prev_walk_q  <= prev_walk_d;
            cnt_main_q   <= cnt_main_d;
            cnt_side_q   <= cnt_side_d;
            cnt_walk_q   <= cnt_walk_d;
            armed_main_q <= armed_main_d;
            armed_side_q <= armed_side_d;
            armed_walk_q <= armed_walk_d;
            seq_valid_q  <= seq_valid_d;
        end
    end

    // Field outputs: pass-through when healthy, flashing red failsafe on fault.
    always_comb begin
        fault     = fault_q;
        faultCode = code_q;
        if (fault_q) begin
            mainOut = flash_q ? RED : 3'b000;
            sideOut = flash_q ? RED : 3'b000;
            walkOut = 1'b0;
        end else begin
            mainOut = mainLights;
            sideOut = sideLights;
            walkOut = walkLamp;
        end
    end

endmodule

// File: doc/traffic_monitor.md
Name: traffic_monitor

Overview:
- Safety monitor that sits at the other end of the traffic controller's light interface.
- Samples mainLights, sideLights and walkLamp every clock and checks encodings, conflicts, phase sequence and phase durations.
- Forwards the lights unchanged while healthy. On the first violation it latches a fault code and forces flashing-red failsafe outputs until cleared.
- One clock tick equals one controller second.

Parameters:
YELLOW_T, 2, required yellow phase length in cycles
WALK_T, 3, required walkLamp-high length in cycles
MIN_GREEN, 6, minimum green phase length in cycles
MAX_GREEN, 12, maximum green phase length in cycles
CNT_W, 4, phase counter width; counters saturate at 2^CNT_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active-low
mainLights  input  3  observed main light: red=100, yellow=010, green=001
sideLights  input  3  observed side light, same encoding
walkLamp  input  1  observed walk lamp
faultClr  input  1  synchronous fault clear, active-high
fault  output  1  sticky fault flag, registered
faultCode  output  3  first fault latched, registered; 0 = none
mainOut  output  3  main light to field
sideOut  output  3  side light to field
walkOut  output  1  walk lamp to field

Behaviour:
- Reset (rst_n=0 at an edge):
  - fault=0, faultCode=0, flash phase=1.
  - Previous-sample registers = 100/100/0. Phase counters = 1.
  - seqValid=0 and per-signal armed flags=0.
- Outputs when fault=0: mainOut=mainLights, sideOut=sideLights, walkOut=walkLamp (combinational pass-through).
- Outputs when fault=1: walkOut=0. mainOut=sideOut=100 when flash=1, 000 when flash=0.
  - flash is set to 1 on the edge fault sets, then toggles every clock.
- Phase tracking, per signal (main, side, walk):
  - Counter counts consecutive cycles of the current value.
  - When the sample differs from the previous sample, the ended phase length = counter; counter reloads to 1.
  - Counter saturates at 2^CNT_W-1.
  - Armed flag sets on the first change after reset or clear. Durations are checked only on phases fully observed (armed at phase start).
- Fault checks, evaluated on the current inputs each cycle. Lowest code wins on simultaneous faults:
  1. Illegal encoding: either light not in {100,010,001}.
  2. Conflict: both lights non-red.
  3. Walk unsafe: walkLamp=1 while either light non-red.
  4. Bad sequence (only when seqValid=1): any light transition green->red, yellow->green or red->yellow.
  5. Yellow time: yellow phase ends with length != YELLOW_T (armed only).
  6. Green time: green ends with length < MIN_GREEN (armed only), or green persists past MAX_GREEN cycles. The max check applies even when unarmed.
  7. Walk time: walkLamp falls with high length != WALK_T (armed only).
- seqValid sets one cycle after reset or clear.
- Fault latching latency: offending inputs sampled at edge N -> fault=1, faultCode valid after edge N.
- Fault is sticky: later faults do not overwrite faultCode.
- Clear: faultClr=1 with no new fault -> fault=0, faultCode=0, armed flags and seqValid cleared, counters=1.
  - faultClr with a simultaneous new fault -> the new fault wins; the code is the new fault's code.
- rst_n=0 takes precedence over everything, including mid-phase; the first partial phase after reset is unchecked for minimum and exact lengths.

Test Plan:
1. Nominal cycle: main G 9, Y 2, side G 6, Y 2, walk (both red) 3, main G 12 -> fault=0 throughout, outputs equal inputs each cycle.
2. Conflict: mainLights=001, sideLights=001 at cycle k -> fault=1, faultCode=2 after edge k. mainOut/sideOut alternate 100,000,100...; walkOut=0.
3. Armed main green 6, yellow 1 cycle, then red -> faultCode=5 at the edge red is sampled. Change that yellow to 2 cycles -> no fault.
4. Green held 13 cycles -> faultCode=6 on the 13th sampled green cycle, even immediately after reset (unarmed).
5. mainLights=011 with walkLamp=1 in the same cycle -> faultCode=1 (priority over 3). Then drive green->red directly -> faultCode stays 1.
6. Fault active, faultClr=1 with clean inputs -> fault=0, faultCode=0. Then a 3-cycle partial green before the first change -> no fault. Then faultClr=1 together with a conflict -> fault=1, faultCode=2.
